dotprod_lanes: RTL and testbench

Parametrised next-generation dot-product engine using the ap_ start/idle/done control protocol. It computes sum(a[i]*b[i]) for i in 0..n-1 as a signed result. Operands are read from two single-port memories that each return LANES elements per word. Read latency is configurable. Tail words are lane-masked, and the result is wide and held until the next start.

---
 rtl/dotprod_lanes.sv | 156 +++++++++++++++
 tb/tb_dotprod_lanes.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dotprod_lanes.sv
// Lane-parallel signed dot-product engine with ap_start/idle/done control.
// Two single-port memories supply LANES elements per word; the result is held until the next ap_done.
module dotprod_lanes #(
  parameter int DATA_W  = 16,
  parameter int LANES   = 4,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1,
  parameter int ACC_W   = 48,
  parameter int N_W     = 20
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      ap_start,
  output logic                      ap_idle,
  output logic                      ap_done,
  output logic [ACC_W-1:0]          ap_return,
  input  logic [N_W-1:0]            n,
  output logic [ADDR_W-1:0]         a_address0,
  output logic                      a_ce0,
  input  logic [LANES*DATA_W-1:0]   a_q0,
  output logic [ADDR_W-1:0]         b_address0,
  output logic                      b_ce0,
  input  logic [LANES*DATA_W-1:0]   b_q0
);

  localparam int LG    = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int REM_W = (LG > 0) ? LG : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                   state;
  logic [N_W-1:0]           words;
  logic [N_W-1:0]           cnt;
  logic [REM_W-1:0]         rem;
  logic [ACC_W-1:0]         acc;
  logic [MEM_LAT-1:0]       vld_pipe;
  logic [LANES-1:0]         mask_pipe [MEM_LAT];
  logic                     p_valid;
  logic [ACC_W-1:0]         p_sum;

  logic [REM_W-1:0]         n_rem;
  logic [N_W-1:0]           n_words;
  logic                     last_word;
  logic [LANES-1:0]         issue_mask;
  logic signed [ACC_W-1:0]  lane_term [LANES];
  logic [ACC_W-1:0]         lane_sum;

  // Ceiling divide by shift plus remainder test, so n = all-ones cannot overflow.
  always_comb begin
    n_rem   = (LANES == 1) ? '0 : n[REM_W-1:0];
    n_words = (n >> LG) + N_W'(n_rem != '0);
  end

  assign last_word = (cnt == words - N_W'(1));

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [2*DATA_W-1:0] prod;
      assign prod = $signed(a_q0[gi*DATA_W +: DATA_W]) * $signed(b_q0[gi*DATA_W +: DATA_W]);
      assign lane_term[gi] = mask_pipe[MEM_LAT-1][gi] ? ACC_W'(prod) : '0;
      assign issue_mask[gi] = !last_word || (rem == '0) || (REM_W'(gi) < rem);
    end
  endgenerate

  always_comb begin
    lane_sum = '0;
    for (int j = 0; j < LANES; j++) begin
      lane_sum = lane_sum + lane_term[j];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= S_IDLE;
      words      <= '0;
      cnt        <= '0;
      rem        <= '0;
      acc        <= '0;
      vld_pipe   <= '0;
      p_valid    <= 1'b0;
      p_sum      <= '0;
      ap_idle    <= 1'b1;
      ap_done    <= 1'b0;
      ap_return  <= '0;
      a_ce0      <= 1'b0;
      b_ce0      <= 1'b0;
      a_address0 <= '0;
      b_address0 <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        mask_pipe[i] <= '0;
      end
    end else begin
      // The tag pipe tracks the memory latency so its tail lines up with q0.
      vld_pipe[0]  <= (state == S_ISSUE);
      mask_pipe[0] <= issue_mask;
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        mask_pipe[i] <= mask_pipe[i-1];
      end
      p_valid <= vld_pipe[MEM_LAT-1];
      p_sum   <= lane_sum;
      if (p_valid) begin
        acc <= acc + p_sum;
      end
      ap_done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (ap_start) begin
            acc     <= '0;
            cnt     <= '0;
            words   <= n_words;
            rem     <= n_rem;
            ap_idle <= 1'b0;
            if (n == '0) begin
              state     <= S_DONE;
              ap_done   <= 1'b1;
              ap_return <= '0;
            end else begin
              state      <= S_ISSUE;
              a_ce0      <= 1'b1;
              b_ce0      <= 1'b1;
              a_address0 <= '0;
              b_address0 <= '0;
            end
          end
        end
        S_ISSUE: begin
          if (last_word) begin
            state <= S_DRAIN;
            a_ce0 <= 1'b0;
            b_ce0 <= 1'b0;
          end else begin
            cnt        <= cnt + N_W'(1);
            a_address0 <= ADDR_W'(cnt + N_W'(1));
            b_address0 <= ADDR_W'(cnt + N_W'(1));
          end
        end
        S_DRAIN: begin
          // Final word is in stage P and nothing is behind it: its sum lands this edge.
          if (p_valid && (vld_pipe == '0)) begin
            state     <= S_DONE;
            ap_done   <= 1'b1;
            ap_return <= acc + p_sum;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          ap_idle <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dotprod_lanes.sv
// Bench for dotprod_lanes: two instances (MEM_LAT=1 and MEM_LAT=3) against a flat-array reference
// model; a scoreboard queue carries expected result, done cycle and word count to a monitor.
module tb_dotprod_lanes;

  typedef struct {
    int          inst;
    logic [47:0] ret;
    longint      done_cyc;
    int          nce;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        st0 = 1'b0, idle0, done0, ace0, bce0;
  logic [47:0] ret0;
  logic [19:0] n0 = '0;
  logic [15:0] aadr0, badr0;
  logic [63:0] aq0 = '0, bq0 = '0;

  logic        st1 = 1'b0, idle1, done1, ace1, bce1;
  logic [47:0] ret1;
  logic [9:0]  n1 = '0;
  logic [15:0] aadr1, badr1;
  logic [63:0] aq1, bq1;
  logic [63:0] pa1 [3];
  logic [63:0] pb1 [3];

  logic signed [15:0] ea [1024];
  logic signed [15:0] eb [1024];
  logic signed [15:0] da [8];
  logic signed [15:0] db [8];

  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  exp_t        sbq[$];
  int          cecnt [2];
  logic [47:0] last_ret [2];

  dotprod_lanes #(.DATA_W(16), .LANES(4), .ADDR_W(16), .MEM_LAT(1), .ACC_W(48), .N_W(20)) u_dut0 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(st0), .ap_idle(idle0), .ap_done(done0),
    .ap_return(ret0), .n(n0),
    .a_address0(aadr0), .a_ce0(ace0), .a_q0(aq0),
    .b_address0(badr0), .b_ce0(bce0), .b_q0(bq0)
  );

  dotprod_lanes #(.DATA_W(16), .LANES(4), .ADDR_W(16), .MEM_LAT(3), .ACC_W(48), .N_W(10)) u_dut1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(st1), .ap_idle(idle1), .ap_done(done1),
    .ap_return(ret1), .n(n1),
    .a_address0(aadr1), .a_ce0(ace1), .a_q0(aq1),
    .b_address0(badr1), .b_ce0(bce1), .b_q0(bq1)
  );

  function automatic logic [63:0] word(input bit isb, input int addr);
    logic [63:0] w;
    for (int j = 0; j < 4; j++) begin
      int idx;
      idx = (addr * 4 + j) % 1024;
      w[j*16 +: 16] = isb ? eb[idx] : ea[idx];
    end
    return w;
  endfunction

  // Memory models: one-cycle registered read, and a three-stage read pipe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ace0) aq0 <= word(1'b0, int'(aadr0));
    if (bce0) bq0 <= word(1'b1, int'(badr0));
    if (ace1) pa1[0] <= word(1'b0, int'(aadr1));
    if (bce1) pb1[0] <= word(1'b1, int'(badr1));
    pa1[1] <= pa1[0];
    pa1[2] <= pa1[1];
    pb1[1] <= pb1[0];
    pb1[2] <= pb1[1];
  end
  assign aq1 = pa1[2];
  assign bq1 = pb1[2];

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic mon(input int k, input logic d, input logic idl, input logic [47:0] r,
                     input logic ace, input logic [15:0] aa, input logic bce, input logic [15:0] ba);
    exp_t e;
    if (ace || bce) begin
      checks++;
      if (!(ace && bce) || aa != 16'(cecnt[k]) || ba != 16'(cecnt[k])) begin
        errors++;
        $display("FAIL issue inst%0d: got a_ce0=%0b b_ce0=%0b a_addr=%0d b_addr=%0d, expected both ce=1 addr=%0d",
                 k, ace, bce, aa, ba, cecnt[k]);
      end
      cecnt[k]++;
    end
    if (d) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done inst%0d: got ap_done=1 at cycle %0d, expected no pulse", k, cyc);
      end else begin
        e = sbq.pop_front();
        if (e.inst != k || r != e.ret || cyc != e.done_cyc || cecnt[k] != e.nce || idl != 1'b0) begin
          errors++;
          $display("FAIL result inst%0d: got inst=%0d ret=%0d cycle=%0d words=%0d idle=%0b, expected inst=%0d ret=%0d cycle=%0d words=%0d idle=0",
                   k, k, $signed(r), cyc, cecnt[k], idl, e.inst, $signed(e.ret), e.done_cyc, e.nce);
        end else begin
          $display("op inst%0d: words=%0d ret=%0d done_cycle=%0d", k, e.nce, $signed(r), cyc);
        end
        last_ret[k] = e.ret;
      end
      cecnt[k] = 0;
    end else if (idl) begin
      checks++;
      if (r != last_ret[k]) begin
        errors++;
        $display("FAIL hold inst%0d: got ap_return=%0d in idle, expected %0d", k, $signed(r), $signed(last_ret[k]));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      cecnt[0] = 0;
      cecnt[1] = 0;
      last_ret[0] = '0;
      last_ret[1] = '0;
    end else begin
      mon(0, done0, idle0, ret0, ace0, aadr0, bce0, badr0);
      mon(1, done1, idle1, ret1, ace1, aadr1, bce1, badr1);
    end
  end

  // Waits for idle, refills memory (first ndir elements from da/db), models, pushes, starts.
  task automatic op(input int k, input int nn, input int ndir, input bit hold);
    int     waitc;
    int     w;
    longint s;
    exp_t   e;
    logic   idl;
    waitc = 0;
    @(negedge clk);
    idl = (k == 0) ? idle0 : idle1;
    while (!idl) begin
      waitc++;
      if (waitc > 5000) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout inst%0d: got ap_idle=0 for 5000 cycles, expected 1", k);
        return;
      end
      @(negedge clk);
      idl = (k == 0) ? idle0 : idle1;
    end
    for (int i = 0; i < 1024; i++) begin
      ea[i] = 16'($urandom());
      eb[i] = 16'($urandom());
    end
    for (int i = 0; i < ndir; i++) begin
      ea[i] = da[i];
      eb[i] = db[i];
    end
    s = 0;
    for (int i = 0; i < nn; i++) begin
      s += longint'(ea[i]) * longint'(eb[i]);
    end
    w = (nn + 3) / 4;
    if (!hold) begin
      e.inst     = k;
      e.ret      = s[47:0];
      e.done_cyc = cyc + ((nn == 0) ? 1 : w + ((k == 0) ? 1 : 3) + 2);
      e.nce      = w;
      sbq.push_back(e);
    end
    if (k == 0) begin
      n0  = 20'(nn);
      st0 = 1'b1;
    end else begin
      n1  = 10'(nn);
      st1 = 1'b1;
    end
    repeat (hold ? 5 : 1) @(negedge clk);
    st0 = 1'b0;
    st1 = 1'b0;
  endtask

  task automatic drain_all();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      pa1[i] = '0;
      pb1[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_idle0", longint'(idle0), 1);
    chk("rst_done0", longint'(done0), 0);
    chk("rst_ret0", longint'(ret0), 0);
    chk("rst_ce0", longint'({ace0, bce0}), 0);
    chk("rst_addr0", longint'({aadr0, badr0}), 0);
    chk("rst_idle1", longint'(idle1), 1);
    chk("rst_ret1", longint'(ret1), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // a = 1..8, b = 1 over n=8; then b = 2 over n=5 with lanes 5..7 holding garbage.
    for (int i = 0; i < 8; i++) begin
      da[i] = 16'(i + 1);
      db[i] = 16'(1);
    end
    op(0, 8, 8, 1'b0);
    for (int i = 0; i < 8; i++) db[i] = 16'(2);
    op(0, 5, 8, 1'b0);
    op(0, 0, 0, 1'b0);
    da[0] = -16'sd3; da[1] = 16'sd4; da[2] = 16'sh8000; da[3] = 16'sd1;
    db[0] = 16'sd5;  db[1] = -16'sd2; db[2] = 16'sh8000; db[3] = 16'sd0;
    op(0, 4, 4, 1'b0);
    repeat (25) op(0, int'($urandom_range(0, 64)), 0, 1'b0);
    drain_all();

    // Start held through ISSUE, then reset during DRAIN: no done, result cleared.
    op(0, 16, 0, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle0", longint'(idle0), 1);
    chk("abort_done0", longint'(done0), 0);
    chk("abort_ret0", longint'(ret0), 0);
    chk("abort_ce0", longint'({ace0, bce0}), 0);

    op(1, 16, 0, 1'b0);
    op(1, 16, 0, 1'b0);
    op(1, 1023, 0, 1'b0);
    repeat (4) op(1, int'($urandom_range(0, 1023)), 0, 1'b0);
    drain_all();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
